// File: rtl/usb_pkg.sv
// Shared types for the USB DP/DM receive path.
// Line symbols, receiver states and SYNC pattern.
package usb_pkg;

  typedef enum logic [1:0] {
    SYM_J,
    SYM_K,
    SYM_SE0,
    SYM_SE1
  } line_sym_t;

  // KJKJKJKK, K=0, first symbol in the MSB
  localparam logic [7:0] SYNC_SYMS = 8'b0101_0100;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RECV,
    EOP,
    WAIT_ACK,
    ERR
  } rx_state_t;

endpackage

// File: rtl/dpdm_sampler.sv
// Two-stage line sampler with J/K/SE0/SE1 decode.
// sym_next is the newer symbol, sym_cur the older.
module dpdm_sampler
  import usb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_L,
  input  logic      dp,
  input  logic      dm,
  output line_sym_t sym_cur,
  output line_sym_t sym_next
);

  line_sym_t sym_in;

  // classify the raw line pair
  always_comb begin
    sym_in = SYM_SE0;
    unique case (1'b1)
      ( dp && !dm): sym_in = SYM_J;
      (!dp &&  dm): sym_in = SYM_K;
      (!dp && !dm): sym_in = SYM_SE0;
      ( dp &&  dm): sym_in = SYM_SE1;
    endcase
  end

  // s1/s2 shift register, idle line is J
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      sym_next <= SYM_J;
      sym_cur  <= SYM_J;
    end else begin
      sym_next <= sym_in;
      sym_cur  <= sym_next;
    end
  end

endmodule

// File: rtl/dpdm_rx.sv
// USB line receiver: frames one packet from DP/DM,
// checks SYNC and EOP, emits raw NRZI levels.
module dpdm_rx
  import usb_pkg::*;
#(
  parameter int MAX_BITS   = 128,
  parameter bit SYNC_CHECK = 1'b1
) (
  input  logic clk,
  input  logic rst_L,
  input  logic dp,
  input  logic dm,
  input  logic sending,
  input  logic ack,
  output logic stream_in,
  output logic bit_valid,
  output logic rcv_start,
  output logic rcv_last,
  output logic EOP_ok,
  output logic rcv_err,
  output logic rcv_busy
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BITS);

  line_sym_t sym_cur;
  line_sym_t sym_next;

  rx_state_t state;
  rx_state_t state_d;

  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_d;
  logic [CW-1:0] bit_inc;
  logic [1:0]    se0_cnt;
  logic [1:0]    se0_cnt_d;
  logic [2:0]    sidx;
  logic          emit;
  logic          start;
  logic          is_jk;
  logic          sym_bit;
  logic          sync_exp;
  logic          line_on;

  dpdm_sampler u_smp (
    .clk      (clk),
    .rst_L    (rst_L),
    .dp       (dp),
    .dm       (dm),
    .sym_cur  (sym_cur),
    .sym_next (sym_next)
  );

  assign is_jk    = (sym_cur == SYM_J) || (sym_cur == SYM_K);
  assign sym_bit  = (sym_cur == SYM_J);
  assign sidx     = bit_cnt[2:0];
  assign sync_exp = SYNC_SYMS[3'd7 - sidx];
  assign bit_inc  = (bit_cnt == MAXC) ? bit_cnt : bit_cnt + CW'(1);
  assign rcv_busy = (state != IDLE);
  assign line_on  = (state == IDLE) || (state == SYNC) ||
                    (state == RECV) || (state == EOP);

  // next-state: one s2 symbol consumed per cycle
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    se0_cnt_d = se0_cnt;
    emit      = 1'b0;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_d = '0;
        if (sym_cur == SYM_K) begin
          state_d   = SYNC;
          start     = 1'b1;
          emit      = 1'b1;
          bit_cnt_d = CW'(1);
        end
      end
      SYNC: begin
        if (bit_cnt == MAXC || !is_jk) begin
          state_d = ERR;
        end else if (SYNC_CHECK && sym_bit != sync_exp) begin
          state_d = ERR;
        end else begin
          emit      = 1'b1;
          bit_cnt_d = bit_inc;
          if (sidx == 3'd7) state_d = RECV;
        end
      end
      RECV: begin
        if (bit_cnt == MAXC) begin
          state_d = ERR;
        end else begin
          unique case (sym_cur)
            SYM_J, SYM_K: begin
              emit      = 1'b1;
              bit_cnt_d = bit_inc;
            end
            SYM_SE0: begin
              state_d   = EOP;
              se0_cnt_d = 2'd1;
            end
            default: state_d = ERR;
          endcase
        end
      end
      EOP: begin
        unique case (sym_cur)
          SYM_SE0: begin
            if (se0_cnt == 2'd1) se0_cnt_d = 2'd2;
            else                 state_d   = ERR;
          end
          SYM_J: begin
            if (se0_cnt == 2'd2) state_d = WAIT_ACK;
            else                 state_d = ERR;
          end
          default: state_d = ERR;
        endcase
      end
      WAIT_ACK: if (ack) state_d = IDLE;
      ERR:      if (ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // local transmit owns the line: drop quietly
    if (sending && line_on) begin
      state_d   = IDLE;
      emit      = 1'b0;
      start     = 1'b0;
      bit_cnt_d = '0;
      se0_cnt_d = '0;
    end
  end

  // state and counters
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state   <= IDLE;
      bit_cnt <= '0;
      se0_cnt <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      se0_cnt <= se0_cnt_d;
    end
  end

  // registered outputs; stream_in holds when idle
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      stream_in <= 1'b1;
      bit_valid <= 1'b0;
      rcv_start <= 1'b0;
      rcv_last  <= 1'b0;
      EOP_ok    <= 1'b0;
      rcv_err   <= 1'b0;
    end else begin
      if (emit) stream_in <= sym_bit;
      bit_valid <= emit;
      rcv_start <= start;
      rcv_last  <= emit && (sym_next == SYM_SE0);
      EOP_ok    <= (state_d == WAIT_ACK);
      rcv_err   <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_dpdm_rx.sv
// Directed bench for dpdm_rx.
// Default instance plus a MAX_BITS=16 instance for timeout.
module tb_dpdm_rx;

  localparam logic [1:0] J  = 2'b10;
  localparam logic [1:0] K  = 2'b01;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b11;

  logic clk = 1'b0;
  logic rst_L, dp, dm, sending, ack;
  logic stream_in, bit_valid, rcv_start, rcv_last;
  logic EOP_ok, rcv_err, rcv_busy;
  logic si16, bv16, st16, la16, ok16, err16, bz16;

  int ntests, nfail;
  int nstart, nlast, start_pos, last_pos, v16, err16_at;
  logic seen_err, seen_ok, seen_busy;
  logic q[$];
  logic exp_q[$];

  always #5 clk = ~clk;

  dpdm_rx u_dut (
    .clk(clk), .rst_L(rst_L), .dp(dp), .dm(dm),
    .sending(sending), .ack(ack),
    .stream_in(stream_in), .bit_valid(bit_valid),
    .rcv_start(rcv_start), .rcv_last(rcv_last),
    .EOP_ok(EOP_ok), .rcv_err(rcv_err), .rcv_busy(rcv_busy)
  );

  dpdm_rx #(.MAX_BITS(16)) u_dut16 (
    .clk(clk), .rst_L(rst_L), .dp(dp), .dm(dm),
    .sending(sending), .ack(ack),
    .stream_in(si16), .bit_valid(bv16),
    .rcv_start(st16), .rcv_last(la16),
    .EOP_ok(ok16), .rcv_err(err16), .rcv_busy(bz16)
  );

  // output recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (bit_valid) q.push_back(stream_in);
    if (rcv_start) begin nstart++; start_pos = q.size(); end
    if (rcv_last) begin nlast++; last_pos = q.size(); end
    if (rcv_err) seen_err = 1'b1;
    if (EOP_ok) seen_ok = 1'b1;
    if (rcv_busy) seen_busy = 1'b1;
    if (bv16) v16++;
    if (err16 && err16_at < 0) err16_at = v16;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    q.delete();
    exp_q.delete();
    nstart = 0; nlast = 0; start_pos = -1; last_pos = -1;
    v16 = 0; err16_at = -1;
    seen_err = 0; seen_ok = 0; seen_busy = 0;
  endtask

  task automatic line(input logic [1:0] s);
    @(posedge clk);
    #2;
    {dp, dm} = s;
  endtask

  task automatic idle(input int n);
    repeat (n) line(J);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    line(J);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_L = 1'b0;
    {dp, dm} = J;
    @(posedge clk);
    #2;
    rst_L = 1'b1;
    idle(2);
  endtask

  task automatic send_sync();
    logic [7:0] p;
    p = 8'b0101_0100;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(p[i]);
      line(p[i] ? J : K);
    end
  endtask

  // NRZI model: 0 toggles, 1 holds; SYNC ends on K
  task automatic send_bytes(input logic [79:0] d, input int nb);
    logic lvl;
    lvl = 1'b0;
    for (int i = 0; i < nb * 8; i++) begin
      if (!d[i]) lvl = ~lvl;
      exp_q.push_back(lvl);
      line(lvl ? J : K);
    end
  endtask

  task automatic check_pkt(input string tag);
    int mm;
    mm = 0;
    chk({tag, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++)
      if (q[i] !== exp_q[i]) mm++;
    chk({tag, "_data"}, mm, 0);
    chk({tag, "_ok"}, EOP_ok, 1);
    chk({tag, "_err"}, seen_err, 0);
    pulse_ack();
    chk({tag, "_ack"}, EOP_ok, 0);
  endtask

  logic [1:0] ack_syms [16];
  logic [15:0] got16;

  initial begin
    ntests = 0; nfail = 0;
    ack_syms = '{K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K};
    rst_L = 1'b0; {dp, dm} = J; sending = 0; ack = 0;
    clr();
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs",
        {stream_in, bit_valid, rcv_start, rcv_last,
         EOP_ok, rcv_err, rcv_busy}, 7'b1000000);
    rst_L = 1'b1;
    idle(3);
    chk("idle_busy", rcv_busy, 0);

    // 1: ACK handshake packet
    clr();
    foreach (ack_syms[i]) line(ack_syms[i]);
    line(S0); line(S0); line(J);
    line(J);
    line(J);
    chk("ack_ok_early", EOP_ok, 0);
    line(J);
    chk("ack_ok", EOP_ok, 1);
    chk("ack_busy_wait", rcv_busy, 1);
    chk("ack_len", q.size(), 16);
    got16 = '0;
    for (int i = 0; i < q.size() && i < 16; i++)
      got16 = {got16[14:0], q[i]};
    chk("ack_levels", got16, 16'b0101_0100_1101_1000);
    chk("ack_start_pos", start_pos, 1);
    chk("ack_last_pos", last_pos, 16);
    chk("ack_pulses", {nstart[3:0], nlast[3:0]}, 8'h11);
    chk("ack_no_err", seen_err, 0);
    idle(3);
    chk("ack_hold", EOP_ok, 1);
    pulse_ack();
    chk("ack_clear", {EOP_ok, rcv_busy}, 2'b00);
    idle(2);

    // 2: OUT token then DATA0 payload
    clr();
    send_sync();
    send_bytes({56'h0, 8'h72, 8'h05, 8'hE1}, 3);
    line(S0); line(S0); line(J);
    idle(3);
    check_pkt("out");
    idle(2);
    clr();
    send_sync();
    send_bytes({8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hBE,
                8'hBA, 8'hFE, 8'hCA, 8'hC3}, 9);
    line(S0); line(S0); line(J);
    idle(3);
    check_pkt("data0");
    idle(2);

    // 3: last SYNC symbol wrong
    clr();
    for (int i = 0; i < 4; i++) begin line(K); line(J); end
    idle(3);
    chk("sync_err", rcv_err, 1);
    chk("sync_len", q.size(), 7);
    idle(4);
    chk("sync_bv_low", bit_valid, 0);
    chk("sync_len_hold", q.size(), 7);
    chk("sync_err_hold", rcv_err, 1);
    pulse_ack();
    chk("sync_ack", {rcv_err, rcv_busy}, 2'b00);

    // 4a: single SE0 before J
    clr();
    send_sync();
    line(J); line(K); line(J); line(J);
    line(S0); line(J);
    idle(3);
    chk("eop1_err", rcv_err, 1);
    chk("eop1_ok", seen_ok, 0);
    pulse_ack();
    // 4b: SE1 mid-packet
    clr();
    send_sync();
    line(K); line(J); line(S1);
    idle(3);
    chk("se1_err", rcv_err, 1);
    pulse_ack();
    // 4c: three SE0
    clr();
    send_sync();
    line(K); line(J);
    line(S0); line(S0); line(S0); line(J);
    idle(3);
    chk("eop3_err", rcv_err, 1);
    chk("eop3_ok", seen_ok, 0);
    pulse_ack();
    chk("eop3_ack", rcv_err, 0);

    // 5: timeout on the 16-symbol instance
    do_reset();
    clr();
    send_sync();
    for (int i = 0; i < 6; i++) begin line(J); line(K); end
    idle(4);
    chk("tmo_err16", err16, 1);
    chk("tmo_at", err16_at, 16);
    chk("tmo_bv16", v16, 16);
    chk("tmo_main_ok", seen_err, 0);

    // 6a: own transmission ignored
    do_reset();
    clr();
    sending = 1'b1;
    foreach (ack_syms[i]) line(ack_syms[i]);
    line(S0); line(S0); line(J);
    idle(4);
    sending = 1'b0;
    idle(2);
    chk("snd_busy", seen_busy, 0);
    chk("snd_start", nstart, 0);
    chk("snd_bits", q.size(), 0);
    chk("snd_ok", seen_ok, 0);

    // 6b: sending raised during RECV
    clr();
    send_sync();
    line(J); line(K); line(K); line(J);
    chk("snd_mid_busy", rcv_busy, 1);
    sending = 1'b1;
    line(K); line(J); line(S0); line(S0); line(J);
    idle(4);
    sending = 1'b0;
    idle(2);
    chk("snd_mid_idle", {rcv_busy, bit_valid}, 2'b00);
    chk("snd_mid_flags", {seen_err, seen_ok}, 2'b00);

    // 6c: reset mid-RECV
    clr();
    send_sync();
    repeat (4) line(K);
    idle(0);
    line(K); line(K); line(K);
    chk("rst_pre", {stream_in, bit_valid, rcv_busy}, 3'b011);
    rst_L = 1'b0;
    #1;
    chk("rst_mid",
        {stream_in, bit_valid, rcv_start, rcv_last,
         EOP_ok, rcv_err, rcv_busy}, 7'b1000000);
    {dp, dm} = J;
    @(posedge clk);
    #2;
    rst_L = 1'b1;
    idle(3);
    chk("rst_after", rcv_busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
